// File: rtl/pwm_seq_ctrl_pkg.sv
// Shared types and constants for the PWM profile sequencer.
// Contents: FSM state enum, profile entry layout, repeat-counter width.
// Entry layout is {pr, dc, ph, of, rep} from MSB to LSB at the default 16-bit resolution.
package pwm_seq_ctrl_pkg;

    localparam int PWM_SEQ_REP_W = 8;
    localparam int PWM_SEQ_N     = 16;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_LOAD = 2'd1,
        SEQ_ARM  = 2'd2,
        SEQ_RUN  = 2'd3
    } pwm_seq_state_t;

    typedef struct packed {
        logic [PWM_SEQ_N-1:0]     pr;
        logic [PWM_SEQ_N-1:0]     dc;
        logic [PWM_SEQ_N-1:0]     ph;
        logic [PWM_SEQ_N-1:0]     of;
        logic [PWM_SEQ_REP_W-1:0] rep;
    } pwm_seq_entry_t;

endpackage

// File: rtl/pwm_seq_tbl.sv
// Profile table: DEPTH x W register file, one synchronous write port, one combinational read port.
// Ports: sys_clk/sys_rst (sync, active-high, clears all entries), wr_en/wr_addr/wr_data, rd_addr/rd_data.
// A write becomes visible on the read port the cycle after the write edge; no backpressure.
module pwm_seq_tbl #(
    parameter int DEPTH = 8,
    parameter int W     = 72
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pwm_seq_ctrl.sv
// PWM profile sequencer: steps through the profile table, writing CFG0/CFG1 and setting LD_TRG per entry.
// Ports: sequence control (seq_start/stop/loop/last), table write port, pr_match_event in; cfg/ld_trg strobes and status out.
// Latency: seq_start at edge t gives the LOAD strobes in cycle t+1; each entry lasts rep+1 PWM periods; no backpressure.
module pwm_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 16,
    parameter int DEPTH      = 8
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     seq_start,
    input  logic                     seq_stop,
    input  logic                     seq_loop,
    input  logic [$clog2(DEPTH)-1:0] seq_last,
    input  logic                     tbl_wr_en,
    input  logic [$clog2(DEPTH)-1:0] tbl_wr_addr,
    input  logic [4*N+7:0]           tbl_wr_data,
    input  logic                     pr_match_event,
    output logic                     cfg_wr_en,
    output logic [DATA_WIDTH-1:0]    cfg0_val,
    output logic [DATA_WIDTH-1:0]    cfg1_val,
    output logic                     ld_trg_set,
    output logic                     seq_busy,
    output logic                     seq_done,
    output logic [$clog2(DEPTH)-1:0] seq_idx
);

    import pwm_seq_ctrl_pkg::*;

    localparam int IW = $clog2(DEPTH);
    localparam int RW = PWM_SEQ_REP_W;
    localparam int EW = 4*N + RW;

    pwm_seq_state_t  state;
    logic [RW-1:0]   rep_cnt;
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   rd_addr;
    logic [EW-1:0]   rd_data;
    logic            enter_load;
    logic            last_entry;

    pwm_seq_tbl #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_tbl (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .wr_en   (tbl_wr_en),
        .wr_addr (tbl_wr_addr),
        .wr_data (tbl_wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign last_entry = (idx_q == seq_last);

    // The read address always points at the entry that the next LOAD would use:
    // entry 0 from IDLE or on a loop wrap, otherwise the successor of the running entry.
    always_comb begin
        rd_addr = '0;
        if (state == SEQ_RUN && !last_entry) begin
            rd_addr = idx_q + IW'(1);
        end
    end

    // Stop has priority over every transition, including a same-cycle start.
    always_comb begin
        enter_load = 1'b0;
        if (!seq_stop) begin
            if (state == SEQ_IDLE && seq_start) begin
                enter_load = 1'b1;
            end else if (state == SEQ_RUN && rep_cnt == '0 && (!last_entry || seq_loop)) begin
                enter_load = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= SEQ_IDLE;
            rep_cnt    <= '0;
            idx_q      <= '0;
            cfg0_val   <= '0;
            cfg1_val   <= '0;
            cfg_wr_en  <= 1'b0;
            ld_trg_set <= 1'b0;
            seq_done   <= 1'b0;
        end else begin
            cfg_wr_en  <= 1'b0;
            ld_trg_set <= 1'b0;
            seq_done   <= 1'b0;

            if (enter_load) begin
                // Table is sampled only here, so edits reach the PWM on the entry's next load.
                state      <= SEQ_LOAD;
                idx_q      <= rd_addr;
                cfg0_val   <= rd_data[EW-1 -: 2*N];
                cfg1_val   <= rd_data[2*N+RW-1 -: 2*N];
                rep_cnt    <= rd_data[RW-1:0];
                cfg_wr_en  <= 1'b1;
                ld_trg_set <= 1'b1;
            end else if (seq_stop) begin
                state <= SEQ_IDLE;
            end else begin
                case (state)
                    SEQ_IDLE: state <= SEQ_IDLE;
                    SEQ_LOAD: state <= SEQ_ARM;
                    // The match in ARM is where the shadows take the new entry; rep_cnt
                    // already holds the entry's rep value from the load.
                    SEQ_ARM: begin
                        if (pr_match_event) begin
                            state <= SEQ_RUN;
                        end
                    end
                    SEQ_RUN: begin
                        if (rep_cnt != '0) begin
                            if (pr_match_event) begin
                                rep_cnt <= rep_cnt - RW'(1);
                            end
                        end else begin
                            // Only the non-looping finish reaches here; the load cases took enter_load.
                            state    <= SEQ_IDLE;
                            seq_done <= 1'b1;
                        end
                    end
                    default: state <= SEQ_IDLE;
                endcase
            end
        end
    end

    assign seq_busy = (state != SEQ_IDLE);
    assign seq_idx  = idx_q;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Testbench for pwm_seq_ctrl: directed sequences with hand-computed expected loads and finishes.
// Expected strobe records are queued by the stimulus and consumed by an independent monitor.
// Status outputs are also checked directly at fixed points after each edge.
module tb_pwm_seq_ctrl;

    import pwm_seq_ctrl_pkg::*;

    localparam int N     = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int IW    = 3;

    logic           sys_clk = 1'b0;
    logic           sys_rst = 1'b1;
    logic           seq_start = 1'b0;
    logic           seq_stop = 1'b0;
    logic           seq_loop = 1'b0;
    logic [IW-1:0]  seq_last = '0;
    logic           tbl_wr_en = 1'b0;
    logic [IW-1:0]  tbl_wr_addr = '0;
    logic [4*N+7:0] tbl_wr_data = '0;
    logic           pr_match_event = 1'b0;
    logic           cfg_wr_en;
    logic [DW-1:0]  cfg0_val;
    logic [DW-1:0]  cfg1_val;
    logic           ld_trg_set;
    logic           seq_busy;
    logic           seq_done;
    logic [IW-1:0]  seq_idx;

    pwm_seq_ctrl #(
        .DATA_WIDTH (DW),
        .N          (N),
        .DEPTH      (DEPTH)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst        (sys_rst),
        .seq_start      (seq_start),
        .seq_stop       (seq_stop),
        .seq_loop       (seq_loop),
        .seq_last       (seq_last),
        .tbl_wr_en      (tbl_wr_en),
        .tbl_wr_addr    (tbl_wr_addr),
        .tbl_wr_data    (tbl_wr_data),
        .pr_match_event (pr_match_event),
        .cfg_wr_en      (cfg_wr_en),
        .cfg0_val       (cfg0_val),
        .cfg1_val       (cfg1_val),
        .ld_trg_set     (ld_trg_set),
        .seq_busy       (seq_busy),
        .seq_done       (seq_done),
        .seq_idx        (seq_idx)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit            is_done;
        logic [IW-1:0] idx;
        logic [DW-1:0] c0;
        logic [DW-1:0] c1;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Monitor: every strobe cycle consumes exactly one queued expectation.
    always @(negedge sys_clk) begin
        if (cfg_wr_en || ld_trg_set || seq_done) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got cfg_wr_en=%0b ld_trg_set=%0b seq_done=%0b idx=%0d, expected no strobe",
                         cfg_wr_en, ld_trg_set, seq_done, seq_idx);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.is_done) begin
                    if (!(seq_done && !cfg_wr_en && !ld_trg_set && seq_idx == e.idx)) begin
                        errors++;
                        $display("FAIL done_pulse: got done=%0b cfg_wr_en=%0b ld_trg=%0b idx=%0d, expected done=1 idx=%0d",
                                 seq_done, cfg_wr_en, ld_trg_set, seq_idx, e.idx);
                    end
                end else begin
                    if (!(cfg_wr_en && ld_trg_set && !seq_done && seq_idx == e.idx &&
                          cfg0_val == e.c0 && cfg1_val == e.c1)) begin
                        errors++;
                        $display("FAIL load_strobe: got wr=%0b ld=%0b done=%0b idx=%0d cfg0=%h cfg1=%h, expected idx=%0d cfg0=%h cfg1=%h",
                                 cfg_wr_en, ld_trg_set, seq_done, seq_idx, cfg0_val, cfg1_val, e.idx, e.c0, e.c1);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_load(input logic [IW-1:0] idx, input logic [DW-1:0] c0, input logic [DW-1:0] c1);
        exp_t e;
        e.is_done = 1'b0; e.idx = idx; e.c0 = c0; e.c1 = c1;
        q.push_back(e);
    endtask

    task automatic push_done(input logic [IW-1:0] idx);
        exp_t e;
        e.is_done = 1'b1; e.idx = idx; e.c0 = '0; e.c1 = '0;
        q.push_back(e);
    endtask

    task automatic wr(input logic [IW-1:0] addr, input logic [15:0] pr, input logic [15:0] dc,
                      input logic [15:0] ph, input logic [15:0] of, input logic [7:0] rep);
        pwm_seq_entry_t ent;
        ent.pr = pr; ent.dc = dc; ent.ph = ph; ent.of = of; ent.rep = rep;
        tbl_wr_en = 1'b1; tbl_wr_addr = addr; tbl_wr_data = ent;
        tick();
        tbl_wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        seq_start = 1'b1; tick(); seq_start = 1'b0;
    endtask

    task automatic ev();
        pr_match_event = 1'b1; tick(); pr_match_event = 1'b0;
    endtask

    // ARM match followed by rep RUN matches; leaves the FSM in RUN with rep_cnt==0.
    task automatic pass(input int rep);
        ev();
        repeat (rep) ev();
    endtask

    initial begin
        // Reset state
        tick(); tick();
        sys_rst = 1'b0;
        chk("rst_busy", 32'(seq_busy), 32'd0);
        chk("rst_idx", 32'(seq_idx), 32'd0);
        chk("rst_cfg0", cfg0_val, 32'h0);
        chk("rst_cfg1", cfg1_val, 32'h0);
        chk("rst_strobe", {30'd0, cfg_wr_en, seq_done}, 32'd0);

        // Two-entry non-looping sequence
        wr(3'd0, 16'd9, 16'd4, 16'd0, 16'd0, 8'd0);
        wr(3'd1, 16'd19, 16'd10, 16'd3, 16'd5, 8'd2);
        seq_last = 3'd1; seq_loop = 1'b0;
        push_load(3'd0, 32'h0009_0004, 32'h0000_0000);
        pulse_start();
        chk("start_busy", 32'(seq_busy), 32'd1);
        chk("start_cfg_wr", 32'(cfg_wr_en), 32'd1);
        tick();
        pass(0);
        push_load(3'd1, 32'h0013_000A, 32'h0003_0005);
        tick(); tick();
        pass(2);
        chk("run_busy_before_done", 32'(seq_busy), 32'd1);
        push_done(3'd1);
        tick();
        chk("done_pulse", 32'(seq_done), 32'd1);
        chk("done_busy", 32'(seq_busy), 32'd0);
        chk("done_cfg0_held", cfg0_val, 32'h0013_000A);
        tick();
        chk("done_one_cycle", 32'(seq_done), 32'd0);

        // Looping sequence, then stop while in ARM
        seq_loop = 1'b1;
        push_load(3'd0, 32'h0009_0004, 32'h0000_0000);
        pulse_start();
        tick();
        for (int k = 0; k < 2; k++) begin
            pass(0);
            push_load(3'd1, 32'h0013_000A, 32'h0003_0005);
            tick(); tick();
            pass(2);
            push_load(3'd0, 32'h0009_0004, 32'h0000_0000);
            tick(); tick();
        end
        chk("loop_in_arm_busy", 32'(seq_busy), 32'd1);
        seq_stop = 1'b1; tick(); seq_stop = 1'b0;
        chk("stop_busy", 32'(seq_busy), 32'd0);
        chk("stop_done", 32'(seq_done), 32'd0);
        chk("stop_cfg0_held", cfg0_val, 32'h0009_0004);
        chk("stop_idx_held", 32'(seq_idx), 32'd0);
        ev(); ev();

        // start and stop together from IDLE
        seq_start = 1'b1; seq_stop = 1'b1; tick(); seq_start = 1'b0; seq_stop = 1'b0;
        chk("start_stop_busy", 32'(seq_busy), 32'd0);
        tick();
        chk("start_stop_busy2", 32'(seq_busy), 32'd0);

        // Rewrite e1 while running e0, and ignored start while busy
        seq_loop = 1'b0;
        wr(3'd0, 16'd9, 16'd4, 16'd0, 16'd0, 8'd3);
        push_load(3'd0, 32'h0009_0004, 32'h0000_0000);
        pulse_start();
        tick();
        ev();
        wr(3'd1, 16'd40, 16'd20, 16'd7, 16'd8, 8'd0);
        pulse_start();
        chk("busy_start_idx", 32'(seq_idx), 32'd0);
        chk("busy_start_no_load", 32'(cfg_wr_en), 32'd0);
        repeat (3) ev();
        push_load(3'd1, 32'h0028_0014, 32'h0007_0008);
        tick(); tick();
        pass(0);
        push_done(3'd1);
        tick();
        chk("rewrite_done_busy", 32'(seq_busy), 32'd0);

        // Match event held high, all entries rep=0
        wr(3'd0, 16'd9, 16'd4, 16'd0, 16'd0, 8'd0);
        wr(3'd2, 16'd30, 16'd15, 16'd1, 16'd2, 8'd0);
        seq_last = 3'd2;
        push_load(3'd0, 32'h0009_0004, 32'h0000_0000);
        push_load(3'd1, 32'h0028_0014, 32'h0007_0008);
        push_load(3'd2, 32'h001E_000F, 32'h0001_0002);
        push_done(3'd2);
        pr_match_event = 1'b1;
        pulse_start();
        repeat (9) tick();
        pr_match_event = 1'b0;
        chk("held_ev_busy", 32'(seq_busy), 32'd0);
        chk("held_ev_idx", 32'(seq_idx), 32'd2);

        // Reset while running entry 2
        wr(3'd2, 16'd30, 16'd15, 16'd1, 16'd2, 8'd2);
        seq_loop = 1'b1;
        push_load(3'd0, 32'h0009_0004, 32'h0000_0000);
        pulse_start();
        tick();
        pass(0);
        push_load(3'd1, 32'h0028_0014, 32'h0007_0008);
        tick(); tick();
        pass(0);
        push_load(3'd2, 32'h001E_000F, 32'h0001_0002);
        tick(); tick();
        ev();
        chk("pre_rst_idx", 32'(seq_idx), 32'd2);
        sys_rst = 1'b1; tick(); sys_rst = 1'b0;
        chk("midrun_rst_busy", 32'(seq_busy), 32'd0);
        chk("midrun_rst_idx", 32'(seq_idx), 32'd0);
        chk("midrun_rst_cfg0", cfg0_val, 32'h0);
        repeat (4) ev();
        chk("post_rst_busy", 32'(seq_busy), 32'd0);

        tick();
        chk("queue_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_seq_ctrl.md
# pwm_seq_ctrl

Sequencer for the n-bit PWM. Holds a small profile table of PWM configurations (period, duty cycle, phase, offset, repeat count) and steps through it, one entry per group of PWM periods. For each entry it writes the PWM CFG0/CFG1 SFRs and sets LD_TRG, so the PWM loads the new values into its shadows at the next period match. It sits between the SFR bank and the PWM, in the same clock domain as the SFR write path.

## Interface
Parameters:
- DATA_WIDTH, 32, SFR width; must equal 2*N.
- N, 16, PWM resolution, i.e. the width of each of pr/dc/ph/of.
- DEPTH, 8, number of profile entries (power of 2, ≥2); IW = $clog2(DEPTH).

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  reset. Synchronous, active-high.
- seq_start  in  1  pulse; starts a sequence from entry 0.
- seq_stop  in  1  pulse; aborts the sequence.
- seq_loop  in  1  level; wrap from seq_last back to entry 0 instead of finishing.
- seq_last  in  IW  index of the final entry.
- tbl_wr_en  in  1  profile table write strobe.
- tbl_wr_addr  in  IW  table write index.
- tbl_wr_data  in  4N+8  entry, packed {pr, dc, ph, of, rep[7:0]}.
- pr_match_event  in  1  period-match event from the PWM (prm_en set).
- cfg_wr_en  out  1  one-cycle strobe; write cfg0_val/cfg1_val into the PWM CFG0/CFG1 SFRs.
- cfg0_val  out  DATA_WIDTH  {pr, dc}.
- cfg1_val  out  DATA_WIDTH  {ph, of}.
- ld_trg_set  out  1  one-cycle strobe; set PWM CTRL.ld_trg.
- seq_busy  out  1  high in every state except IDLE.
- seq_done  out  1  one-cycle pulse when a non-looping sequence finishes.
- seq_idx  out  IW  index of the entry currently loaded or running.

## Operation
- Profile table: DEPTH entries, one write port, one combinational read port. A write is visible on the next cycle.
- Writes are legal while busy. The table is read only on entry into LOAD, so edits take effect the next time that entry is loaded.
- States: IDLE, LOAD, ARM, RUN.
- IDLE:
  - seq_start → LOAD with idx=0.
  - The table entry is registered into cfg0_val/cfg1_val/rep_cnt on the transition.
- LOAD (exactly 1 cycle): cfg_wr_en=1 and ld_trg_set=1 → ARM.
- ARM: wait for pr_match_event, which marks the point where the shadows take the new entry. On the event, rep_cnt←rep → RUN.
- RUN, rep_cnt≠0: each pr_match_event decrements rep_cnt.
- RUN, rep_cnt==0 (no event needed):
  - idx≠seq_last → LOAD with idx+1.
  - idx==seq_last and seq_loop=1 → LOAD with idx=0.
  - Otherwise → IDLE with seq_done=1 for that transition cycle.
- Result: an entry stays active for exactly rep+1 PWM periods. After a finish, the last entry stays active in the PWM.
- seq_stop: from any state, → IDLE on the next edge. No seq_done pulse. cfg0_val/cfg1_val/seq_idx hold.
- seq_start while busy is ignored. If seq_start and seq_stop arrive in the same cycle, stop wins.
- pr_match_event during LOAD or IDLE is ignored.
- Software constraint: every entry must have pr ≥ 3, so LOAD always completes before the next match.
- rep_cnt is 8 bits, unsigned. Decrement happens only when rep_cnt≠0; no wrap-around.
- seq_last > DEPTH-1 cannot occur, since the port is IW bits wide.

## Timing
- Reset (sys_rst=1 at an edge):
  - state=IDLE.
  - All outputs 0: cfg0_val, cfg1_val, seq_idx, strobes, seq_busy, seq_done.
  - rep_cnt=0; table cleared to 0.
  - Reset mid-sequence aborts immediately; no strobes are issued.
- seq_start sampled at edge t → LOAD during cycle t+1: cfg_wr_en, ld_trg_set and seq_busy high, and cfg values valid in that same cycle. ARM from t+2.
- pr_match_event sampled in ARM at edge e → RUN at e+1.
- RUN with rep_cnt==0 at cycle c → LOAD at c+1.
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.

## Structure
- pkg_sfrs_definition gains:
  - pwm_seq_state_t (enum IDLE/LOAD/ARM/RUN).
  - pwm_seq_entry_t (packed struct pr, dc, ph, of, rep).
  - Constant PWM_SEQ_REP_W=8.
- Sub-module pwm_seq_tbl: DEPTH×pwm_seq_entry_t register file, sync write, async read, synchronous clear on sys_rst.
- FSM, rep counter and output registers live in pwm_seq_ctrl.

## Test plan
- Reset mid-RUN (idx=2) → next cycle: seq_busy=0, seq_idx=0, cfg0_val=0; no further strobes on later pr_match_event.
- Table e0={pr=9,dc=4,ph=0,of=0,rep=0}, e1={pr=19,dc=10,rep=2}, seq_last=1, seq_loop=0; start at t:
  - cfg_wr_en at t+1 with cfg0_val=0x0009_0004.
  - After 1 event, LOAD with cfg0_val=0x0013_000A.
  - After 1 more event (ARM) and 2 RUN events: seq_done pulse, seq_busy=0.
- Same table with seq_loop=1 → seq_idx sequence 0,1,0,1…; ld_trg_set once per entry; never seq_done.
- seq_stop while in ARM → IDLE next cycle, no seq_done, cfg0_val held. seq_start+seq_stop in the same cycle from IDLE → stays IDLE.
- While RUN on e0 (rep=3), rewrite e1 → the following LOAD shows the new e1 values. seq_start while busy → no restart, seq_idx unchanged.
- pr_match_event held high continuously with rep=0 → entries advance one per ARM/RUN pass; rep_cnt never underflows.
